// File: rtl/wb_master_pkg.sv
// Shared types, default widths and width helpers for the Wishbone classic master.
package wb_master_pkg;

   localparam int unsigned DEF_AW = 32;
   localparam int unsigned DEF_DW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic int unsigned sel_width(input int unsigned dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/wb_classic_master_if.sv
// Request/response port plus Wishbone classic bus signals of the single-cycle master.
interface wb_classic_master_if
   import wb_master_pkg::*;
#(
   parameter int unsigned AW   = DEF_AW,
   parameter int unsigned DW   = DEF_DW,
   parameter int unsigned SELW = sel_width(DW)
);

   logic            req_valid_i;
   logic            req_ready_o;
   logic            req_we_i;
   logic [AW-1:0]   req_adr_i;
   logic [DW-1:0]   req_dat_i;
   logic [SELW-1:0] req_sel_i;

   logic            rsp_valid_o;
   logic [DW-1:0]   rsp_dat_o;
   logic            rsp_err_o;

   logic            wb_cyc_o;
   logic            wb_stb_o;
   logic            wb_we_o;
   logic [AW-1:0]   wb_adr_o;
   logic [DW-1:0]   wb_dat_o;
   logic [SELW-1:0] wb_sel_o;
   logic            wb_ack_i;
   logic [DW-1:0]   wb_dat_i;

   modport master (
      input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, wb_ack_i, wb_dat_i,
      output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, wb_ack_i, wb_dat_i,
      input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );

endinterface

// File: rtl/wb_timeout_counter.sv
// Ack-wait counter: flags the cycle in which the wait would reach LIMIT cycles.
module wb_timeout_counter #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_c
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expires on the edge that would complete the LIMIT-th waiting cycle.
   assign expired_c = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_classic_master.sv
// Wishbone B4 classic master: one SINGLE READ/WRITE bus cycle per request.
// Optional ack timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_classic_master
   import wb_master_pkg::*;
#(
   parameter int unsigned AW             = DEF_AW,
   parameter int unsigned DW             = DEF_DW,
   parameter int unsigned SELW           = sel_width(DW),
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   wb_classic_master_if.master bus
);

   state_e          state_q, state_d;
   logic            ready_q, ready_d;
   logic            cyc_q, cyc_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
   logic            rsp_err_q, rsp_err_d;
   logic            accept_c;
   logic            timeout_c;

   assign accept_c = (state_q == IDLE) && bus.req_valid_i;

`ifdef WB_MASTER_TIMEOUT_EN
   logic wait_en_c;

   assign wait_en_c = (state_q == BUS) && !bus.wb_ack_i;

   wb_timeout_counter #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n_i),
      .clr_i    (accept_c),
      .en_i     (wait_en_c),
      .expired_c(timeout_c)
   );
`else
   // Without the timeout the limit has no effect and BUS waits for ack forever.
   assign timeout_c = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid_i) state_d = BUS;
         BUS:     if (bus.wb_ack_i || timeout_c) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ack wins over a same-cycle timeout; errors and writes return zero data.
   always_comb begin
      ready_d     = ready_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = 1'b0;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (accept_c) begin
               ready_d = 1'b0;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = bus.req_we_i;
               adr_d   = bus.req_adr_i;
               dat_d   = bus.req_we_i ? bus.req_dat_i : '0;
               sel_d   = bus.req_sel_i;
            end
         end
         BUS: begin
            ready_d = 1'b0;
            if (bus.wb_ack_i || timeout_c) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = !bus.wb_ack_i;
               rsp_dat_d   = (bus.wb_ack_i && !we_q) ? bus.wb_dat_i : '0;
            end
         end
         RESP: begin
            ready_d = 1'b1;
         end
         default: begin
            ready_d = 1'b1;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ready_q     <= 1'b1;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         ready_q     <= ready_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready_o = ready_q;
   assign bus.wb_cyc_o    = cyc_q;
   assign bus.wb_stb_o    = stb_q;
   assign bus.wb_we_o     = we_q;
   assign bus.wb_adr_o    = adr_q;
   assign bus.wb_dat_o    = dat_q;
   assign bus.wb_sel_o    = sel_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_dat_o   = rsp_dat_q;
   assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_classic_master.sv
// Bench for wb_classic_master: vector table, hand sequences and random transactions.
module tb_wb_classic_master;

   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   wb_classic_master_if #(.AW(32), .DW(32)) bus ();

   wb_classic_master #(
      .AW(32), .DW(32), .SELW(4), .TIMEOUT_CYCLES(TO)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_n_i(rst_n),
      .bus       (bus)
   );

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          ack_at;
      logic [31:0] rdata;
      int          bus_len;
      logic [31:0] exp_rsp;
      bit          exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level expectation: bus length, response data and error flag.
   function automatic void model(input bit we, input int ack_at, input logic [31:0] rdata,
                                 output int len, output logic [31:0] rsp, output bit err);
      len = ack_at;
      err = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      if (ack_at == 0 || ack_at > int'(TO)) begin
         len = int'(TO);
         err = 1'b1;
      end
`endif
      rsp = (err || we) ? 32'h0 : rdata;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the response.
   task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                          input int bus_len, input logic [31:0] exp_rsp, input bit exp_err);
      logic [31:0] exp_wdat;
      exp_wdat = we ? dat : 32'h0;
      bus.wb_ack_i = 1'b0;
      chk("idle_ready", 32'(bus.req_ready_o), 32'd1);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_adr_i   = adr;
      bus.req_dat_i   = dat;
      bus.req_sel_i   = sel;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = ~we;
      bus.req_adr_i   = $urandom;
      bus.req_dat_i   = $urandom;
      bus.req_sel_i   = 4'($urandom);
      for (int c = 1; c <= bus_len; c++) begin
         chk("bus_cyc", 32'(bus.wb_cyc_o), 32'd1);
         chk("bus_stb", 32'(bus.wb_stb_o), 32'd1);
         chk("bus_we", 32'(bus.wb_we_o), 32'(we));
         chk("bus_adr", bus.wb_adr_o, adr);
         chk("bus_dat", bus.wb_dat_o, exp_wdat);
         chk("bus_sel", 32'(bus.wb_sel_o), 32'(sel));
         chk("bus_ready", 32'(bus.req_ready_o), 32'd0);
         chk("bus_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
         if (c == ack_at) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = rdata;
         end
         @(negedge clk);
         bus.wb_ack_i = 1'b0;
         bus.wb_dat_i = $urandom;
      end
      chk("resp_cyc", 32'(bus.wb_cyc_o), 32'd0);
      chk("resp_stb", 32'(bus.wb_stb_o), 32'd0);
      chk("resp_we", 32'(bus.wb_we_o), 32'd0);
      chk("resp_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("resp_dat", bus.rsp_dat_o, exp_rsp);
      chk("resp_err", 32'(bus.rsp_err_o), 32'(exp_err));
      chk("resp_ready", 32'(bus.req_ready_o), 32'd0);
      bus.wb_ack_i = 1'(($urandom % 2));
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      chk("post_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("post_ready", 32'(bus.req_ready_o), 32'd1);
      chk("post_cyc", 32'(bus.wb_cyc_o), 32'd0);
      chk("post_dat_hold", bus.rsp_dat_o, exp_rsp);
      chk("post_err_hold", 32'(bus.rsp_err_o), 32'(exp_err));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs[5];
      int          len;
      logic [31:0] rsp;
      bit          err;

      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 32'h0, 2, 32'h0, 1'b0};
      vecs[1] = '{1'b0, 32'h20, 32'h0, 4'hF, 3, 32'h12345678, 3, 32'h12345678, 1'b0};
      vecs[2] = '{1'b0, 32'h24, 32'h55AA55AA, 4'hC, 1, 32'hA5A50F0F, 1, 32'hA5A50F0F, 1'b0};
      vecs[3] = '{1'b1, 32'h30, 32'h0000BEEF, 4'h3, 1, 32'hFFFFFFFF, 1, 32'h0, 1'b0};
      vecs[4] = '{1'b0, 32'hFFFFFFFC, 32'h0, 4'h1, 5, 32'hCAFEF00D, 5, 32'hCAFEF00D, 1'b0};

      rst_n = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_adr_i   = '0;
      bus.req_dat_i   = '0;
      bus.req_sel_i   = '0;
      bus.wb_ack_i    = 1'b0;
      bus.wb_dat_i    = '0;

      // Reset held 5 cycles; bus must stay idle throughout.
      repeat (5) begin
         @(negedge clk);
         chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
         chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(bus.req_ready_o), 32'd1);
      chk("rel_we", 32'(bus.wb_we_o), 32'd0);
      chk("rel_adr", bus.wb_adr_o, 32'h0);
      chk("rel_dat", bus.wb_dat_o, 32'h0);
      chk("rel_sel", 32'(bus.wb_sel_o), 32'd0);
      chk("rel_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("rel_rsp_dat", bus.rsp_dat_o, 32'h0);
      chk("rel_rsp_err", 32'(bus.rsp_err_o), 32'd0);
      // Stray acks while idle are ignored.
      for (int i = 0; i < 4; i++) begin
         bus.wb_ack_i = 1'(i % 2);
         @(negedge clk);
         chk("idle_stb", 32'(bus.wb_stb_o), 32'd0);
         chk("idle_cyc", 32'(bus.wb_cyc_o), 32'd0);
         chk("idle_rsp", 32'(bus.rsp_valid_o), 32'd0);
      end
      bus.wb_ack_i = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].ack_at,
                 vecs[i].rdata, vecs[i].bus_len, vecs[i].exp_rsp, vecs[i].exp_err);
      end

      // Back-to-back write then read with req_valid held high.
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_adr_i   = 32'h100;
      bus.req_dat_i   = 32'h0BADF00D;
      bus.req_sel_i   = 4'hF;
      @(negedge clk);
      bus.req_we_i    = 1'b0;
      bus.req_adr_i   = 32'h104;
      bus.req_dat_i   = 32'h77777777;
      chk("b2b_w_cyc", 32'(bus.wb_cyc_o), 32'd1);
      chk("b2b_w_adr", bus.wb_adr_o, 32'h100);
      chk("b2b_w_we", 32'(bus.wb_we_o), 32'd1);
      bus.wb_ack_i = 1'b1;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      chk("b2b_gap1_cyc", 32'(bus.wb_cyc_o), 32'd0);
      chk("b2b_rsp1_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("b2b_rsp1_dat", bus.rsp_dat_o, 32'h0);
      @(negedge clk);
      chk("b2b_gap2_cyc", 32'(bus.wb_cyc_o), 32'd0);
      chk("b2b_gap2_rsp", 32'(bus.rsp_valid_o), 32'd0);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      chk("b2b_r_cyc", 32'(bus.wb_cyc_o), 32'd1);
      chk("b2b_r_we", 32'(bus.wb_we_o), 32'd0);
      chk("b2b_r_adr", bus.wb_adr_o, 32'h104);
      chk("b2b_r_dat", bus.wb_dat_o, 32'h0);
      bus.wb_ack_i = 1'b1;
      bus.wb_dat_i = 32'h89ABCDEF;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      chk("b2b_rsp2_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("b2b_rsp2_dat", bus.rsp_dat_o, 32'h89ABCDEF);
      @(negedge clk);
      chk("b2b_end_valid", 32'(bus.rsp_valid_o), 32'd0);

      // Reset asserted in the second BUS cycle drops the request silently.
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_adr_i   = 32'h40;
      bus.req_dat_i   = 32'h11223344;
      bus.req_sel_i   = 4'hF;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      chk("rmid_bus1_cyc", 32'(bus.wb_cyc_o), 32'd1);
      @(negedge clk);
      chk("rmid_bus2_cyc", 32'(bus.wb_cyc_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rmid_cyc", 32'(bus.wb_cyc_o), 32'd0);
      chk("rmid_stb", 32'(bus.wb_stb_o), 32'd0);
      chk("rmid_we", 32'(bus.wb_we_o), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("rmid_hold_rsp", 32'(bus.rsp_valid_o), 32'd0);
         chk("rmid_hold_cyc", 32'(bus.wb_cyc_o), 32'd0);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rmid_after_rsp", 32'(bus.rsp_valid_o), 32'd0);
         chk("rmid_after_ready", 32'(bus.req_ready_o), 32'd1);
      end
      run_txn(1'b0, 32'h44, 32'h0, 4'hF, 2, 32'h5A5A1234, 2, 32'h5A5A1234, 1'b0);

`ifdef WB_MASTER_TIMEOUT_EN
      run_txn(1'b0, 32'h50, 32'h0, 4'hF, 0, 32'h13579BDF, int'(TO), 32'h0, 1'b1);
      run_txn(1'b0, 32'h54, 32'h0, 4'hF, int'(TO), 32'h2468ACE0, int'(TO), 32'h2468ACE0, 1'b0);
      run_txn(1'b1, 32'h58, 32'hFEEDFACE, 4'hF, int'(TO) + 1, 32'h0, int'(TO), 32'h0, 1'b1);
`endif

      // Random transactions checked against the transaction-level model.
      for (int i = 0; i < 30; i++) begin
         bit          we;
         logic [31:0] adr, dat, rdata;
         logic [3:0]  sel;
         int          ack_at;
         we    = 1'($urandom % 2);
         adr   = $urandom;
         dat   = $urandom;
         rdata = $urandom;
         sel   = 4'($urandom);
`ifdef WB_MASTER_TIMEOUT_EN
         ack_at = int'($urandom_range(0, 12));
`else
         ack_at = int'($urandom_range(1, 6));
`endif
         model(we, ack_at, rdata, len, rsp, err);
         run_txn(we, adr, dat, sel, ack_at, rdata, len, rsp, err);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            bus.wb_ack_i = 1'($urandom % 2);
            @(negedge clk);
            chk("gap_cyc", 32'(bus.wb_cyc_o), 32'd0);
            chk("gap_rsp", 32'(bus.rsp_valid_o), 32'd0);
         end
         bus.wb_ack_i = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
